// File: rtl/wfifo_cap_pkg.sv
// -----------------------------------------------------------------------------
// wfifo_cap_pkg
// Shared definitions for the waveform-FIFO capture controller: the FSM state
// encoding (also driven out on the controller's state port) and the trigger
// mode codes accepted on trig_mode.
// -----------------------------------------------------------------------------
package wfifo_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [1:0] TRIG_RISING   = 2'b00;
    localparam logic [1:0] TRIG_FALLING  = 2'b01;
    localparam logic [1:0] TRIG_FORCE    = 2'b10;
    localparam logic [1:0] TRIG_EXTERNAL = 2'b11;

endpackage

// File: rtl/wfifo_cap_packer.sv
// -----------------------------------------------------------------------------
// wfifo_cap_packer
// Packs c_PACK consecutive samples little-endian into one FIFO word.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   clear         discard any partially packed word
//   sample_valid  sample is to be packed this cycle
//   sample        sample value
//   word_next     buffer contents with the current sample merged in
//   word_ready    high in the cycle whose sample completes a word; word_next
//                 then holds the complete word
// -----------------------------------------------------------------------------
module wfifo_cap_packer #(
    parameter int c_SAMPLE_WIDTH = 8,
    parameter int c_PACK         = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               sample_valid,
    input  logic [c_SAMPLE_WIDTH-1:0]          sample,
    output logic [c_SAMPLE_WIDTH*c_PACK-1:0]   word_next,
    output logic                               word_ready
);

    localparam int IDX_WIDTH = (c_PACK > 1) ? $clog2(c_PACK) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(c_PACK - 1);

    logic [c_SAMPLE_WIDTH*c_PACK-1:0] buffer;
    logic [IDX_WIDTH-1:0]             idx;

    // Slot idx receives the incoming sample, so the k-th sample of a word
    // lands in bits [k*W +: W].
    always_comb begin
        word_next = buffer;
        word_next[int'(idx)*c_SAMPLE_WIDTH +: c_SAMPLE_WIDTH] = sample;
    end

    assign word_ready = sample_valid && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buffer <= '0;
            idx    <= '0;
        end else if (clear) begin
            buffer <= '0;
            idx    <= '0;
        end else if (sample_valid) begin
            if (word_ready) begin
                buffer <= '0;
                idx    <= '0;
            end else begin
                buffer <= word_next;
                idx    <= idx + IDX_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/wfifo_capture_ctrl.sv
// -----------------------------------------------------------------------------
// wfifo_capture_ctrl
// Triggered ADC capture into a write FIFO. After an arm pulse the controller
// decimates the sample stream, waits for a trigger (rising/falling level
// crossing, forced, or external edge), then packs cap_len FIFO words of
// samples and returns to idle through a one-cycle DONE state.
// Ports:
//   wr_clk, wr_rst_n            clock, synchronous active-low reset
//   arm, abort                  start / cancel pulses (abort has priority)
//   trig_mode, trig_level       trigger selection and level threshold
//   ext_trig                    external trigger input (rising edge used)
//   cap_len, decim              words per capture, keep 1 of decim+1 samples
//   adc_data, adc_valid         sample stream, no backpressure
//   wr_data, wr_en, wr_full     FIFO write port
//   state, busy, triggered,
//   done, overflow              status
// -----------------------------------------------------------------------------
module wfifo_capture_ctrl
    import wfifo_cap_pkg::*;
#(
    parameter int c_SAMPLE_WIDTH = 8,
    parameter int c_PACK         = 4,
    parameter int c_LEN_WIDTH    = 16,
    parameter int c_DEC_WIDTH    = 8
) (
    input  logic                              wr_clk,
    input  logic                              wr_rst_n,
    input  logic                              arm,
    input  logic                              abort,
    input  logic [1:0]                        trig_mode,
    input  logic [c_SAMPLE_WIDTH-1:0]         trig_level,
    input  logic                              ext_trig,
    input  logic [c_LEN_WIDTH-1:0]            cap_len,
    input  logic [c_DEC_WIDTH-1:0]            decim,
    input  logic [c_SAMPLE_WIDTH-1:0]         adc_data,
    input  logic                              adc_valid,
    output logic [c_SAMPLE_WIDTH*c_PACK-1:0]  wr_data,
    output logic                              wr_en,
    input  logic                              wr_full,
    output logic [1:0]                        state,
    output logic                              busy,
    output logic                              triggered,
    output logic                              done,
    output logic                              overflow
);

    cap_state_t                   st;
    logic [1:0]                   mode_q;
    logic [c_SAMPLE_WIDTH-1:0]    level_q;
    logic [c_SAMPLE_WIDTH-1:0]    prev_q;
    logic [c_LEN_WIDTH-1:0]       len_q;
    logic [c_LEN_WIDTH-1:0]       word_cnt;
    logic [c_DEC_WIDTH-1:0]       decim_q;
    logic [c_DEC_WIDTH-1:0]       dec_cnt;
    logic                         have_prev;
    logic                         ext_q;
    logic                         pending;

    logic                         running;
    logic                         accept;
    logic                         trig_hit;
    logic                         arm_ok;
    logic                         cap_sample;
    logic                         pack_clear;
    logic [c_SAMPLE_WIDTH*c_PACK-1:0] word_next;
    logic                         word_ready;

    assign running    = (st == ST_ARMED) || (st == ST_CAPTURE);
    assign accept     = running && adc_valid && (dec_cnt == '0);
    assign arm_ok     = (st == ST_IDLE) && arm && (cap_len != '0) && !abort;
    assign pack_clear = abort || arm_ok;

    // Level triggers need a previous accepted sample, so the first accepted
    // sample after arming can never fire them.
    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            TRIG_RISING:   trig_hit = have_prev && (prev_q <  level_q) && (adc_data >= level_q);
            TRIG_FALLING:  trig_hit = have_prev && (prev_q >= level_q) && (adc_data <  level_q);
            TRIG_FORCE:    trig_hit = 1'b1;
            TRIG_EXTERNAL: trig_hit = pending;
            default:       trig_hit = 1'b0;
        endcase
    end

    // The triggering sample is itself captured. Once the last word is counted
    // no further samples are packed while the FSM moves on to DONE.
    assign cap_sample = !abort && accept &&
                        (((st == ST_ARMED) && trig_hit) ||
                         ((st == ST_CAPTURE) && (word_cnt != len_q)));

    wfifo_cap_packer #(
        .c_SAMPLE_WIDTH (c_SAMPLE_WIDTH),
        .c_PACK         (c_PACK)
    ) u_packer (
        .clk          (wr_clk),
        .rst_n        (wr_rst_n),
        .clear        (pack_clear),
        .sample_valid (cap_sample),
        .sample       (adc_data),
        .word_next    (word_next),
        .word_ready   (word_ready)
    );

    // Main FSM with registered status and FIFO write outputs. The full flag is
    // judged at the edge that completes a word: a full FIFO drops the word
    // (still counted) and latches overflow instead of issuing wr_en.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            st        <= ST_IDLE;
            mode_q    <= '0;
            level_q   <= '0;
            prev_q    <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            decim_q   <= '0;
            dec_cnt   <= '0;
            have_prev <= 1'b0;
            ext_q     <= 1'b0;
            pending   <= 1'b0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            ext_q <= ext_trig;

            if (abort) begin
                st        <= ST_IDLE;
                triggered <= 1'b0;
                pending   <= 1'b0;
                have_prev <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        if (arm_ok) begin
                            st        <= ST_ARMED;
                            mode_q    <= trig_mode;
                            level_q   <= trig_level;
                            len_q     <= cap_len;
                            decim_q   <= decim;
                            dec_cnt   <= '0;
                            word_cnt  <= '0;
                            prev_q    <= '0;
                            have_prev <= 1'b0;
                            pending   <= 1'b0;
                            overflow  <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (ext_trig && !ext_q) begin
                            pending <= 1'b1;
                        end
                        if (accept) begin
                            prev_q    <= adc_data;
                            have_prev <= 1'b1;
                        end
                        if (cap_sample) begin
                            st        <= ST_CAPTURE;
                            triggered <= 1'b1;
                            pending   <= 1'b0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (word_cnt == len_q) begin
                            st   <= ST_DONE;
                            done <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        st        <= ST_IDLE;
                        triggered <= 1'b0;
                    end
                    default: st <= ST_IDLE;
                endcase

                if (running && adc_valid) begin
                    dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + c_DEC_WIDTH'(1);
                end

                if (word_ready) begin
                    word_cnt <= word_cnt + c_LEN_WIDTH'(1);
                    if (wr_full) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_data <= word_next;
                    end
                end
            end
        end
    end

    assign state = st;
    assign busy  = running;

endmodule

// File: tb/tb_wfifo_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wfifo_capture_ctrl
// Directed bench for wfifo_capture_ctrl: inputs change 1 ns after the rising
// edge, outputs are inspected 1 ns after the rising edge that updated them.
// A negedge monitor counts FIFO write pulses and any write seen while full.
// -----------------------------------------------------------------------------
module tb_wfifo_capture_ctrl;

    logic        wr_clk;
    logic        wr_rst_n;
    logic        arm;
    logic        abort;
    logic [1:0]  trig_mode;
    logic [7:0]  trig_level;
    logic        ext_trig;
    logic [15:0] cap_len;
    logic [7:0]  decim;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic [1:0]  state;
    logic        busy;
    logic        triggered;
    logic        done;
    logic        overflow;

    int checkCount = 0;
    int errorCount = 0;
    int wrPulses = 0;
    int fullWrites = 0;
    int pulseBase;

    wfifo_capture_ctrl dut (
        .wr_clk     (wr_clk),
        .wr_rst_n   (wr_rst_n),
        .arm        (arm),
        .abort      (abort),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .ext_trig   (ext_trig),
        .cap_len    (cap_len),
        .decim      (decim),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_full    (wr_full),
        .state      (state),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .overflow   (overflow)
    );

    // Free-running 100 MHz clock.
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // Count write pulses mid-cycle and flag any write issued against a full FIFO.
    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) begin
            wrPulses++;
            if (wr_full === 1'b1) fullWrites++;
        end
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        adc_valid = valid;
        adc_data  = data;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic armPulse(input logic [1:0] mode, input logic [7:0] level,
                            input logic [15:0] len, input logic [7:0] dec);
        trig_mode  = mode;
        trig_level = level;
        cap_len    = len;
        decim      = dec;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        wr_rst_n   = 1'b0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_mode  = 2'b00;
        trig_level = 8'h00;
        ext_trig   = 1'b0;
        cap_len    = 16'd0;
        decim      = 8'd0;
        adc_data   = 8'h00;
        adc_valid  = 1'b0;
        wr_full    = 1'b0;

        // Reset values
        tick();
        tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_triggered", triggered, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_overflow", overflow, 0);
        wr_rst_n = 1'b1;
        tick();

        // Arm with zero length is ignored
        armPulse(2'b10, 8'h00, 16'd0, 8'd0);
        checkOutput("zero_len_state", state, 0);

        // Forced trigger, two words
        $display("[TB] force capture, two words");
        pulseBase = wrPulses;
        armPulse(2'b10, 8'h00, 16'd2, 8'd0);
        checkOutput("force_armed_state", state, 1);
        checkOutput("force_armed_busy", busy, 1);
        applyStimulus(1'b1, 8'h01);
        checkOutput("force_cap_state", state, 2);
        checkOutput("force_triggered", triggered, 1);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h04);
        checkOutput("force_w0_en", wr_en, 1);
        checkOutput("force_w0_data", wr_data, 32'h04030201);
        applyStimulus(1'b1, 8'h05);
        checkOutput("force_w0_pulse_end", wr_en, 0);
        applyStimulus(1'b1, 8'h06);
        applyStimulus(1'b1, 8'h07);
        applyStimulus(1'b1, 8'h08);
        checkOutput("force_w1_en", wr_en, 1);
        checkOutput("force_w1_data", wr_data, 32'h08070605);
        checkOutput("force_w1_state", state, 2);
        applyStimulus(1'b0, 8'h00);
        checkOutput("force_done", done, 1);
        checkOutput("force_done_state", state, 3);
        checkOutput("force_done_wr_en", wr_en, 0);
        tick();
        checkOutput("force_idle_state", state, 0);
        checkOutput("force_idle_done", done, 0);
        checkOutput("force_idle_triggered", triggered, 0);
        checkOutput("force_pulses", wrPulses - pulseBase, 2);

        // Rising-level trigger at 0x80
        $display("[TB] rising trigger");
        armPulse(2'b00, 8'h80, 16'd1, 8'd0);
        applyStimulus(1'b1, 8'h10);
        applyStimulus(1'b1, 8'h70);
        checkOutput("rise_wait_state", state, 1);
        applyStimulus(1'b1, 8'h90);
        checkOutput("rise_trig_state", state, 2);
        applyStimulus(1'b1, 8'hA0);
        applyStimulus(1'b1, 8'hB0);
        applyStimulus(1'b1, 8'hC0);
        checkOutput("rise_w0_en", wr_en, 1);
        checkOutput("rise_w0_data", wr_data, 32'hC0B0A090);
        tick();
        checkOutput("rise_done", done, 1);
        tick();

        // Decimation by 3 with forced trigger
        $display("[TB] decimation");
        armPulse(2'b10, 8'h00, 16'd1, 8'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i));
        end
        checkOutput("decim_en", wr_en, 1);
        checkOutput("decim_data", wr_data, 32'h09060300);
        applyStimulus(1'b1, 8'h0A);
        checkOutput("decim_done", done, 1);
        tick();

        // FIFO full during the second of three words
        $display("[TB] overflow");
        pulseBase = wrPulses;
        armPulse(2'b10, 8'h00, 16'd3, 8'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("ovf_w0_en", wr_en, 1);
        applyStimulus(1'b1, 8'h05);
        wr_full = 1'b1;
        for (int i = 6; i <= 8; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("ovf_w1_dropped", wr_en, 0);
        checkOutput("ovf_flag", overflow, 1);
        wr_full = 1'b0;
        for (int i = 9; i <= 12; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("ovf_w2_en", wr_en, 1);
        checkOutput("ovf_w2_data", wr_data, 32'h0C0B0A09);
        tick();
        checkOutput("ovf_done", done, 1);
        tick();
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_pulses", wrPulses - pulseBase, 2);
        checkOutput("ovf_full_writes", fullWrites, 0);

        // Abort mid-word, then re-arm
        $display("[TB] abort");
        pulseBase = wrPulses;
        armPulse(2'b10, 8'h00, 16'd1, 8'd0);
        checkOutput("abort_arm_clears_ovf", overflow, 0);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_state", state, 0);
        checkOutput("abort_triggered", triggered, 0);
        checkOutput("abort_done", done, 0);
        tick();
        checkOutput("abort_done_after", done, 0);
        checkOutput("abort_no_write", wrPulses - pulseBase, 0);
        abort = 1'b1;
        armPulse(2'b10, 8'h00, 16'd1, 8'd0);
        abort = 1'b0;
        checkOutput("abort_beats_arm", state, 0);
        armPulse(2'b10, 8'h00, 16'd1, 8'd0);
        checkOutput("rearm_state", state, 1);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(8'h30 + i));
        checkOutput("rearm_data", wr_data, 32'h34333231);
        tick();
        tick();

        // External trigger; arm during capture ignored
        $display("[TB] external trigger");
        armPulse(2'b11, 8'h00, 16'd1, 8'd0);
        applyStimulus(1'b1, 8'h55);
        checkOutput("ext_no_edge_state", state, 1);
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        checkOutput("ext_pending_state", state, 1);
        applyStimulus(1'b1, 8'h66);
        checkOutput("ext_trig_state", state, 2);
        arm = 1'b1;
        applyStimulus(1'b1, 8'h77);
        arm = 1'b0;
        checkOutput("ext_arm_ignored", state, 2);
        applyStimulus(1'b1, 8'h88);
        applyStimulus(1'b1, 8'h99);
        checkOutput("ext_data", wr_data, 32'h99887766);
        tick();
        checkOutput("ext_done", done, 1);
        tick();

        // Reset in the middle of a capture
        $display("[TB] reset mid-capture");
        pulseBase = wrPulses;
        armPulse(2'b10, 8'h00, 16'd2, 8'd0);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        wr_rst_n = 1'b0;
        tick();
        checkOutput("midrst_state", state, 0);
        checkOutput("midrst_wr_en", wr_en, 0);
        wr_rst_n = 1'b1;
        tick();
        checkOutput("midrst_after_wr_en", wr_en, 0);
        checkOutput("midrst_no_write", wrPulses - pulseBase, 0);
        armPulse(2'b10, 8'h00, 16'd1, 8'd0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i));
        checkOutput("midrst_new_word", wr_data, 32'hA4A3A2A1);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/wfifo_capture_ctrl.md
WFIFO_CAPTURE_CTRL -- requirements
Module: wfifo_capture_ctrl

Interface
REQ-001 Parameter c_SAMPLE_WIDTH, default 8, ADC sample width in bits.
REQ-002 Parameter c_PACK, default 4, samples packed per FIFO word; wr_data width = c_SAMPLE_WIDTH*c_PACK (32).
REQ-003 Parameter c_LEN_WIDTH, default 16, width of capture length in FIFO words.
REQ-004 Parameter c_DEC_WIDTH, default 8, width of decimation factor.
REQ-005 Ports: wr_clk in 1 -- the only clock; wr_rst_n in 1 -- synchronous, active-low reset.
REQ-006 arm in 1 -- start-capture pulse; abort in 1 -- cancel pulse.
REQ-007 trig_mode in 2 -- 00 rising, 01 falling, 10 force, 11 external; trig_level in c_SAMPLE_WIDTH; ext_trig in 1.
REQ-008 cap_len in c_LEN_WIDTH -- words per capture; decim in c_DEC_WIDTH -- keep 1 of every decim+1 valid samples.
REQ-009 adc_data in c_SAMPLE_WIDTH; adc_valid in 1 -- sample strobe, no backpressure.
REQ-010 wr_data out 32; wr_en out 1; wr_full in 1 -- FIFO write-side handshake.
REQ-011 state out 2; busy out 1; triggered out 1; done out 1; overflow out 1.

Function
REQ-012 FSM states IDLE=0, ARMED=1, CAPTURE=2, DONE=3, output on state.
REQ-013 IDLE: arm=1 and cap_len!=0 -> ARMED next cycle; trig_mode, trig_level, cap_len, decim latched; decimation counter, packer, word counter, overflow cleared; arm with cap_len=0 ignored.
REQ-014 arm in any state other than IDLE is ignored.
REQ-015 Decimation: counter advances per adc_valid, wraps at decim; sample accepted when counter==0; decim=0 accepts every valid sample; counter runs in ARMED and CAPTURE.
REQ-016 ARMED rising: trigger on accepted sample with prev<trig_level and cur>=trig_level (unsigned); falling: prev>=trig_level and cur<trig_level; first accepted sample after arm only loads prev.
REQ-017 ARMED force: first accepted sample triggers; external: registered ext_trig rising edge sets pending flag, next accepted sample triggers.
REQ-018 Triggering sample is the first captured sample; state -> CAPTURE; triggered=1 from that cycle until leaving CAPTURE/DONE.
REQ-019 Packing little-endian: k-th captured sample of a word goes to bits [8k+7:8k], k=0..3.
REQ-020 Word completes on 4th sample; wr_en=1 for exactly one cycle, the cycle after that sample's adc_valid, wr_data held stable that cycle.
REQ-021 wr_en SHALL never assert while wr_full=1; a completed word seeing wr_full=1 is dropped, overflow set (sticky until next accepted arm), word still counted.
REQ-022 Word counter reaching cap_len -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-023 abort=1 in any state -> IDLE next cycle, partial word discarded, done not asserted; abort wins over simultaneous arm or trigger.
REQ-024 busy=1 in ARMED and CAPTURE; wr_en=0 outside CAPTURE.
REQ-025 Word counter width c_LEN_WIDTH; cap_len=2^c_LEN_WIDTH-1 completes without wrap.

Reset
REQ-026 wr_rst_n=0 sampled at wr_clk edge: state=IDLE, wr_en=0, wr_data=0, busy=0, triggered=0, done=0, overflow=0, all counters and prev/pending flags 0.
REQ-027 Reset mid-capture discards partial word; no wr_en in reset cycle or first cycle after release.

Structure
REQ-028 Shared package wfifo_cap_pkg holds state encoding and trig_mode constants.
REQ-029 One sub-module wfifo_cap_packer: sample shift/pack, word-ready pulse, clear input.

Verification
REQ-030 Force, decim=0, cap_len=2, samples 01..08 -> wr_data 0x04030201 then 0x08070605, two wr_en pulses, done one cycle later, state IDLE.
REQ-031 Rising, level 0x80, samples 10,70,90,A0,B0,C0 -> trigger on 0x90; first word 0xC0B0A090.
REQ-032 decim=2, force, cap_len=1, samples 00..0B -> word 0x09060300.
REQ-033 wr_full=1 during second word, cap_len=3 -> only 2 wr_en pulses, overflow=1, done asserted.
REQ-034 abort after 2 captured samples -> IDLE next cycle, no wr_en, no done; re-arm succeeds.
REQ-035 External mode, ext_trig pulse with decim=0 -> capture starts on next valid sample; arm during CAPTURE ignored.
